// File: rtl/sha3_pkg.sv
// Shared constants and state encoding for the SHA3 padder/unpadder datapath.
package sha3_pkg;

  localparam int unsigned WORD_W         = 64;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int unsigned BN_W           = $clog2(BYTES_PER_WORD);

  localparam logic [BYTE_W-1:0] PAD_FIRST = 8'h01;
  localparam logic [BYTE_W-1:0] PAD_LAST  = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT
  } state_t;

endpackage

// File: rtl/pad_locator.sv
// Combinational pad finder: the highest nonzero byte of the block (with the
// closing 0x80 bit removed) must be 0x01; its index is the message length.
module pad_locator
  import sha3_pkg::*;
#(
  parameter  int unsigned RW = 9,
  localparam int unsigned NB = BYTES_PER_WORD * RW,
  localparam int unsigned LW = $clog2(NB)
) (
  input  logic [WORD_W*RW-1:0] block,
  output logic [LW-1:0]        len,
  output logic                 err
);

  logic              found;
  logic [BYTE_W-1:0] hi_byte;
  logic [BYTE_W-1:0] cur;

  // Priority encoder: later (higher) nonzero bytes override earlier ones.
  always_comb begin
    found   = 1'b0;
    hi_byte = '0;
    len     = '0;
    cur     = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      cur = block[WORD_W*(RW-1-b/BYTES_PER_WORD) + BYTE_W*(b%BYTES_PER_WORD) +: BYTE_W];
      if (b == NB-1) begin
        cur = cur & ~PAD_LAST;
      end
      if (cur != '0) begin
        found   = 1'b1;
        hi_byte = cur;
        len     = LW'(b);
      end
    end
  end

  // Last block byte lives in bits [63:56] of the last word.
  assign err = ((block[WORD_W-1 -: BYTE_W] & PAD_LAST) == '0) || !found ||
               (hi_byte != PAD_FIRST);

endmodule

// File: rtl/unpadder.sv
// SHA3 unpadder: takes padded rate blocks, strips the pad from the final block
// and streams the message as 64-bit words with a byte count on the last one.
module unpadder
  import sha3_pkg::*;
#(
  parameter int unsigned RATE_WORDS = 9
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WORD_W*RATE_WORDS-1:0] in_block,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [WORD_W-1:0]            out_word,
  output logic [2:0]                   out_byte_num,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         pad_err
);

  localparam int unsigned RW    = RATE_WORDS;
  localparam int unsigned BLK_W = WORD_W * RW;
  localparam int unsigned NB    = BYTES_PER_WORD * RW;
  localparam int unsigned LW    = $clog2(NB);
  localparam int unsigned CNT_W = $clog2(RW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RW - 1);

  state_t            state_q, state_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     loc_len;
  logic              loc_err;
  logic [CNT_W-1:0]  final_idx;
  logic              is_last;

  logic              in_ready_d;
  logic [WORD_W-1:0] out_word_d;
  logic [2:0]        out_byte_num_d;
  logic              out_valid_d;
  logic              out_last_d;
  logic              pad_err_d;

  // The pad is located on the incoming block so length and error are
  // registered at accept; SCAN then presents the verdict.
  pad_locator #(.RW(RW)) u_pad_locator (
    .block (in_block),
    .len   (loc_len),
    .err   (loc_err)
  );

  // Next-state and next-output logic; outputs are computed from the next state.
  always_comb begin
    state_d        = state_q;
    blk_d          = blk_q;
    cnt_d          = cnt_q;
    last_d         = last_q;
    len_d          = len_q;
    in_ready_d     = 1'b0;
    out_word_d     = '0;
    out_byte_num_d = '0;
    out_valid_d    = 1'b0;
    out_last_d     = 1'b0;
    pad_err_d      = 1'b0;
    is_last        = 1'b0;
    final_idx      = last_q ? CNT_W'(len_q >> BN_W) : CNT_MAX;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          blk_d     = in_block;
          cnt_d     = '0;
          last_d    = in_last;
          len_d     = loc_len;
          pad_err_d = in_last && loc_err;
          state_d   = in_last ? SCAN : EMIT;
        end
      end
      SCAN: begin
        state_d = pad_err ? IDLE : EMIT;
      end
      EMIT: begin
        if (out_valid && out_ready) begin
          if (cnt_q == final_idx) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);

    if (state_d == EMIT) begin
      out_valid_d = 1'b1;
      is_last     = last_d && (cnt_d == CNT_W'(len_d >> BN_W));
      for (int unsigned w = 0; w < RW; w++) begin
        if (cnt_d == CNT_W'(w)) begin
          out_word_d = blk_d[WORD_W*(RW-1-w) +: WORD_W];
        end
      end
      if (is_last) begin
        out_last_d     = 1'b1;
        out_byte_num_d = len_d[BN_W-1:0];
        for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
          if (BN_W'(k) >= len_d[BN_W-1:0]) begin
            out_word_d[BYTE_W*k +: BYTE_W] = '0;
          end
        end
      end
    end
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      len_q        <= '0;
      in_ready     <= 1'b1;
      out_word     <= '0;
      out_byte_num <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      pad_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      len_q        <= len_d;
      in_ready     <= in_ready_d;
      out_word     <= out_word_d;
      out_byte_num <= out_byte_num_d;
      out_valid    <= out_valid_d;
      out_last     <= out_last_d;
      pad_err      <= pad_err_d;
    end
  end

  // Block register is pure datapath; its contents only matter once accepted.
  always_ff @(posedge clk) begin
    blk_q <= blk_d;
  end

endmodule

// File: tb/tb_unpadder.sv
// Directed bench for the unpadder: streaming, pad stripping, errors, stall, reset.
module tb_unpadder;

  localparam int unsigned RW = 9;
  localparam int unsigned NB = 8 * RW;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [64*RW-1:0] in_block;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic [63:0]     out_word;
  logic [2:0]      out_byte_num;
  logic            out_valid;
  logic            out_last;
  logic            out_ready;
  logic            pad_err;

  unpadder #(.RATE_WORDS(RW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_block     (in_block),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_word     (out_word),
    .out_byte_num (out_byte_num),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .pad_err      (pad_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  bytes [NB];
  logic [63:0] q_word [$];
  logic [2:0]  q_bn   [$];
  logic        q_last [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_bytes();
    for (int b = 0; b < NB; b++) bytes[b] = 8'h00;
  endtask

  // Byte b sits in word b/8 (word 0 at the top of the block), lane b%8.
  function automatic logic [64*RW-1:0] pack();
    logic [64*RW-1:0] r;
    r = '0;
    for (int b = 0; b < NB; b++) r[64*(RW-1-b/8) + 8*(b%8) +: 8] = bytes[b];
    return r;
  endfunction

  // Expected message word w with bytes at index >= lim forced to zero.
  function automatic logic [63:0] exp_word(input int w, input int lim);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) if (w*8 + k < lim) r[8*k +: 8] = bytes[w*8 + k];
    return r;
  endfunction

  // Offer one block; returns at the falling edge just after acceptance.
  task automatic send(input logic last);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 64'(in_ready), 64'd1);
    in_block = pack();
    in_valid = 1'b1;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Gather n_exp words; optionally stall 3 cycles when word stall_at is shown.
  task automatic collect(input int n_exp, input int stall_at);
    logic [63:0] ref_w;
    int cyc = 0;
    int stall = stall_at;
    q_word.delete();
    q_bn.delete();
    q_last.delete();
    out_ready = 1'b1;
    while (q_word.size() < n_exp && cyc < 100) begin
      if (out_valid) begin
        if (q_word.size() == stall) begin
          out_ready = 1'b0;
          ref_w = out_word;
          repeat (3) begin
            @(negedge clk);
            check("hold_word", out_word, ref_w);
            check("hold_valid", 64'(out_valid), 64'd1);
          end
          out_ready = 1'b1;
          stall = -1;
        end
        q_word.push_back(out_word);
        q_bn.push_back(out_byte_num);
        q_last.push_back(out_last);
      end
      @(negedge clk);
      cyc++;
    end
    if (q_word.size() < n_exp) check("collect_count", 64'(q_word.size()), 64'(n_exp));
  endtask

  task automatic check_word(input int i, input logic [63:0] w, input logic [2:0] bn, input logic last);
    if (i < q_word.size()) begin
      check($sformatf("word%0d", i), q_word[i], w);
      check($sformatf("bn%0d", i), 64'(q_bn[i]), 64'(bn));
      check($sformatf("last%0d", i), 64'(q_last[i]), 64'(last));
    end else begin
      check($sformatf("missing%0d", i), 64'(q_word.size()), 64'(i + 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_last"}, 64'(out_last), 64'd0);
    check({tag, "_byte_num"}, 64'(out_byte_num), 64'd0);
    check({tag, "_out_word"}, out_word, 64'd0);
    check({tag, "_pad_err"}, 64'(pad_err), 64'd0);
  endtask

  task automatic load_pattern_1();
    clear_bytes();
    for (int b = 0; b < NB; b++) bytes[b] = 8'(8'h11 * (b/8 + 1));
  endtask

  task automatic load_l13();
    clear_bytes();
    for (int b = 0; b < 13; b++) bytes[b] = 8'(8'hA0 + b);
    bytes[13] = 8'h01;
    bytes[71] = 8'h80;
  endtask

  task automatic bad_block(input string tag);
    send(1'b1);
    check({tag, "_pulse"}, 64'(pad_err), 64'd1);
    check({tag, "_scan_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_scan_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_pulse_end"}, 64'(pad_err), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    check({tag, "_no_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    in_block  = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;

    // 1: non-final block streams all nine words.
    load_pattern_1();
    send(1'b0);
    check("t1_latency", 64'(out_valid), 64'd1);
    collect(9, -1);
    for (int w = 0; w < 9; w++) check_word(w, 64'h1111_1111_1111_1111 * 64'(w + 1), 3'd0, 1'b0);
    check("t1_valid_drop", 64'(out_valid), 64'd0);

    // 2: empty message, single zero word with byte_num 0.
    clear_bytes();
    bytes[0]  = 8'h01;
    bytes[71] = 8'h80;
    send(1'b1);
    check("t2_scan_gap", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("t2_latency", 64'(out_valid), 64'd1);
    collect(1, -1);
    check_word(0, 64'h0, 3'd0, 1'b1);

    // 3: 13-byte message.
    load_l13();
    send(1'b1);
    @(negedge clk);
    collect(2, -1);
    check_word(0, 64'hA7A6_A5A4_A3A2_A1A0, 3'd0, 1'b0);
    check_word(1, 64'h0000_00AC_ABAA_A9A8, 3'd5, 1'b1);

    // 4 + 6A: 71-byte message with a 3-cycle stall on word 4.
    clear_bytes();
    for (int b = 0; b < 71; b++) bytes[b] = 8'(b + 1);
    bytes[71] = 8'h81;
    send(1'b1);
    @(negedge clk);
    collect(9, 4);
    for (int w = 0; w < 8; w++) check_word(w, exp_word(w, 71), 3'd0, 1'b0);
    check_word(8, 64'h0047_4645_4443_4241, 3'd7, 1'b1);
    check("t4_word0_const", q_word.size() > 0 ? q_word[0] : 64'hx, 64'h0807_0605_0403_0201);

    // 5: malformed pads.
    clear_bytes();
    bytes[0] = 8'h01;
    bad_block("t5_no80");
    clear_bytes();
    bytes[5]  = 8'h02;
    bytes[71] = 8'h80;
    bad_block("t5_hi02");
    clear_bytes();
    bytes[71] = 8'h80;
    bad_block("t5_empty");

    // 6B: reset in the middle of EMIT, then a fresh block.
    load_pattern_1();
    out_ready = 1'b0;
    send(1'b0);
    check("t6_emitting", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6_rst");
    reset_n = 1'b1;
    load_l13();
    send(1'b1);
    @(negedge clk);
    collect(2, -1);
    check_word(0, 64'hA7A6_A5A4_A3A2_A1A0, 3'd0, 1'b0);
    check_word(1, 64'h0000_00AC_ABAA_A9A8, 3'd5, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
